pc_sequencer: RTL and testbench

Control block for the program counter in the 3-stage pipeline (fetch / decode / execute). Each cycle it decides whether the PC increments, holds, or loads a new target, and drives the counter's IPC/LPC/load-value inputs. It resolves branch, call and return redirects, keeps a small return-address stack, squashes wrong-path instructions, and implements halt/resume and stall.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter control for a fetch/decode/execute pipeline. It chooses increment, hold
// or load each cycle, resolves branch/call/return redirects and keeps a return-address stack.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] pc_cur,
    input  logic         stall,
    input  logic         br_taken,
    input  logic         call,
    input  logic         ret,
    input  logic [N-1:0] br_target,
    input  logic         halt,
    input  logic         resume,
    output logic         IPC,
    output logic         LPC,
    output logic [N-1:0] pc_load_val,
    output logic         flush,
    output logic         halted,
    output logic         stk_overflow,
    output logic         stk_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    state_t         state;
    state_t         state_next;
    logic [AW:0]    sp;
    logic [N-1:0]   stack [DEPTH];
    logic [N-1:0]   pc_inc;
    logic [AW-1:0]  top_idx;
    logic           stk_full;
    logic           stk_empty;
    logic           push;
    logic           pop;
    logic           ovf_set;
    logic           unf_set;

    assign pc_inc    = pc_cur + N'(1);
    assign top_idx   = sp[AW-1:0] - AW'(1);
    assign stk_full  = (sp == SP_FULL);
    assign stk_empty = (sp == '0);
    assign halted    = (state == HALTED);

    always_comb begin
        state_next  = state;
        IPC         = 1'b0;
        LPC         = 1'b0;
        pc_load_val = '0;
        flush       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (br_taken) begin
                    LPC         = 1'b1;
                    pc_load_val = br_target;
                    flush       = 1'b1;
                    state_next  = FLUSH;
                end else if (call) begin
                    LPC         = 1'b1;
                    pc_load_val = br_target;
                    flush       = 1'b1;
                    state_next  = FLUSH;
                    ovf_set     = stk_full;
                    push        = !stk_full;
                end else if (ret) begin
                    // An empty stack falls through to the next sequential address.
                    LPC         = 1'b1;
                    pc_load_val = stk_empty ? pc_inc : stack[top_idx];
                    flush       = 1'b1;
                    state_next  = FLUSH;
                    unf_set     = stk_empty;
                    pop         = !stk_empty;
                end else if (!stall) begin
                    IPC = 1'b1;
                end
            end
            FLUSH: begin
                // Redirects and stall here come from squashed instructions; only halt counts.
                flush = 1'b1;
                if (halt) begin
                    state_next = HALTED;
                end else begin
                    IPC        = 1'b1;
                    state_next = RUN;
                end
            end
            HALTED: begin
                if (resume) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (clear) begin
            IPC         = 1'b0;
            LPC         = 1'b0;
            pc_load_val = '0;
            flush       = 1'b1;
            push        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state         <= RUN;
            sp            <= '0;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
        end else begin
            state <= state_next;
            if (push)     sp <= sp + (AW+1)'(1);
            else if (pop) sp <= sp - (AW+1)'(1);
            if (ovf_set) stk_overflow  <= 1'b1;
            if (unf_set) stk_underflow <= 1'b1;
        end
    end

    // Stack contents survive clear; resetting the pointer makes them unreachable.
    always_ff @(posedge clk) begin
        if (push) stack[sp[AW-1:0]] <= pc_inc;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a modelled program counter follows IPC/LPC, and each
// scenario pushes expected outputs to a scoreboard queue and checks them per cycle.
`timescale 1ns/1ps
module tb_pc_sequencer;

    typedef struct packed {
        logic       halt;
        logic       resume;
        logic       stall;
        logic       br;
        logic       call;
        logic       ret;
        logic [3:0] tgt;
    } stim_t;

    typedef struct packed {
        logic [3:0] pc;
        logic       ipc;
        logic       lpc;
        logic [3:0] val;
        logic       flush;
        logic       halted;
        logic       ovf;
        logic       unf;
    } obs_t;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] pc = 4'd0;
    logic       stall = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic       halt = 1'b0, resume = 1'b0;
    logic [3:0] br_target = 4'd0;
    logic       IPC, LPC, flush, halted, stk_overflow, stk_underflow;
    logic [3:0] pc_load_val;

    obs_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    pc_sequencer #(.N(4), .DEPTH(4)) dut (
        .clk(clk), .clear(clear), .pc_cur(pc), .stall(stall), .br_taken(br_taken),
        .call(call), .ret(ret), .br_target(br_target), .halt(halt), .resume(resume),
        .IPC(IPC), .LPC(LPC), .pc_load_val(pc_load_val), .flush(flush), .halted(halted),
        .stk_overflow(stk_overflow), .stk_underflow(stk_underflow)
    );

    always #5 clk = ~clk;

    // The program counter being controlled.
    always @(posedge clk or posedge clear) begin
        if (clear)    pc <= 4'd0;
        else if (IPC) pc <= pc + 4'd1;
        else if (LPC) pc <= pc_load_val;
    end

    function automatic stim_t S(input logic h, r, st, b, c, rt, input logic [3:0] t);
        stim_t x;
        x.halt = h; x.resume = r; x.stall = st; x.br = b; x.call = c; x.ret = rt; x.tgt = t;
        return x;
    endfunction

    function automatic obs_t E(input logic [3:0] p, input logic i, l, input logic [3:0] v,
                               input logic f, h, o, u);
        obs_t x;
        x.pc = p; x.ipc = i; x.lpc = l; x.val = v; x.flush = f; x.halted = h; x.ovf = o; x.unf = u;
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x.pc = pc; x.ipc = IPC; x.lpc = LPC; x.val = pc_load_val; x.flush = flush;
        x.halted = halted; x.ovf = stk_overflow; x.unf = stk_underflow;
        return x;
    endfunction

    task automatic drive(input stim_t x);
        halt = x.halt; resume = x.resume; stall = x.stall;
        br_taken = x.br; call = x.call; ret = x.ret; br_target = x.tgt;
    endtask

    localparam stim_t IDLE = '0;

    task automatic test_reset();
        obs_t got, want;
        for (int i = 0; i < 2; i++) begin
            drive(IDLE);
            exp_q.push_back(E(0, 0, 0, 0, 1, 0, 0, 0));
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
        clear = 1'b0;
    endtask

    task automatic test_free_run();
        obs_t got, want;
        for (int i = 0; i < 17; i++) begin
            drive(IDLE);
            exp_q.push_back(E(4'(i), 1, 0, 0, 0, 0, 0, 0));
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL free_run[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        stim_t s [6];
        obs_t  e [6];
        obs_t  got, want;
        s = '{IDLE, IDLE, S(0,0,0,1,0,0,9), S(0,0,0,1,0,0,2), IDLE, IDLE};
        e = '{E(1,1,0,0,0,0,0,0), E(2,1,0,0,0,0,0,0), E(3,0,1,9,1,0,0,0),
              E(9,1,0,0,1,0,0,0), E(10,1,0,0,0,0,0,0), E(11,1,0,0,0,0,0,0)};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL branch[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_call_ret();
        stim_t s [7];
        obs_t  e [7];
        obs_t  got, want;
        s = '{S(0,0,0,1,0,0,4), IDLE, S(0,0,0,0,1,0,12), IDLE, S(0,0,0,0,0,1,0), IDLE, IDLE};
        e = '{E(12,0,1,4,1,0,0,0), E(4,1,0,0,1,0,0,0), E(5,0,1,12,1,0,0,0),
              E(12,1,0,0,1,0,0,0), E(13,0,1,6,1,0,0,0), E(6,1,0,0,1,0,0,0),
              E(7,1,0,0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL call_ret[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stack_limits();
        stim_t s [23];
        obs_t  e [23];
        obs_t  got, want;
        stim_t c1, rt;
        c1 = S(0,0,0,0,1,0,1);
        rt = S(0,0,0,0,0,1,0);
        s = '{c1, IDLE, c1, IDLE, c1, IDLE, c1, IDLE, c1, IDLE,
              rt, IDLE, rt, IDLE, rt, IDLE, rt, IDLE,
              S(0,0,0,1,0,0,14), IDLE, rt, IDLE, IDLE};
        e = '{E(8,0,1,1,1,0,0,0), E(1,1,0,0,1,0,0,0), E(2,0,1,1,1,0,0,0), E(1,1,0,0,1,0,0,0),
              E(2,0,1,1,1,0,0,0), E(1,1,0,0,1,0,0,0), E(2,0,1,1,1,0,0,0), E(1,1,0,0,1,0,0,0),
              E(2,0,1,1,1,0,0,0), E(1,1,0,0,1,0,1,0),
              E(2,0,1,3,1,0,1,0), E(3,1,0,0,1,0,1,0), E(4,0,1,3,1,0,1,0), E(3,1,0,0,1,0,1,0),
              E(4,0,1,3,1,0,1,0), E(3,1,0,0,1,0,1,0), E(4,0,1,9,1,0,1,0), E(9,1,0,0,1,0,1,0),
              E(10,0,1,14,1,0,1,0), E(14,1,0,0,1,0,1,0), E(15,0,1,0,1,0,1,0),
              E(0,1,0,0,1,0,1,1), E(1,1,0,0,0,0,1,1)};
        for (int i = 0; i < 23; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL stack_limits[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        stim_t s [9];
        obs_t  e [9];
        obs_t  got, want;
        s = '{S(1,0,0,1,0,0,9), IDLE, S(0,0,0,1,0,0,9), S(0,1,0,0,0,0,0), IDLE,
              S(0,0,0,1,0,0,6), S(1,0,0,0,0,0,0), S(0,1,0,0,0,0,0), IDLE};
        e = '{E(2,0,0,0,0,0,1,1), E(2,0,0,0,0,1,1,1), E(2,0,0,0,0,1,1,1),
              E(2,0,0,0,0,1,1,1), E(2,1,0,0,0,0,1,1), E(3,0,1,6,1,0,1,1),
              E(6,0,0,0,1,0,1,1), E(6,0,0,0,0,1,1,1), E(6,1,0,0,0,0,1,1)};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL halt[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        stim_t s [4];
        obs_t  e [4];
        obs_t  got, want;
        s = '{S(0,0,1,0,0,0,0), S(0,0,1,1,0,0,3), S(0,0,1,0,0,0,0), IDLE};
        e = '{E(7,0,0,0,0,0,1,1), E(7,0,1,3,1,0,1,1), E(3,1,0,0,1,0,1,1), E(4,1,0,0,0,0,1,1)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL stall[%0d] got=%b required=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear_mid_flush();
        stim_t s [5];
        obs_t  e [5];
        obs_t  got, want;
        s = '{S(0,0,0,1,0,0,11), IDLE, IDLE, IDLE, IDLE};
        e = '{E(5,0,1,11,1,0,1,1), E(11,1,0,0,1,0,1,1), E(0,0,0,0,1,0,0,0),
              E(0,1,0,0,0,0,0,0), E(1,1,0,0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 4) @(negedge clk);
            if (i == 2) begin #2; clear = 1'b1; end
            if (i == 3) begin @(negedge clk); clear = 1'b0; end
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL clear_mid_flush[%0d] got=%b required=%b", i, got, want);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1 clear = 1'b1;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_branch();
        test_call_ret();
        test_stack_limits();
        test_halt();
        test_stall();
        test_clear_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
